seq_div: RTL and testbench

- Multi-cycle restoring (shift-subtract) unsigned integer divider.
- Inverse companion to the team's sequential multiplier; sits on the same datapath.
- Accepts one dividend/divisor pair per start pulse and retires one quotient bit per clock.
- Returns quotient and remainder with a one-cycle done pulse.

---
 rtl/seq_div_pkg.sv | 22 ++
 rtl/div_step.sv | 35 +++
 rtl/seq_div.sv | 177 +++++++++++++++++
 tb/tb_seq_div.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared constants, state encoding and helpers for seq_div
//
// Purpose: state encoding, default operand width and counter sizing helper
// shared by seq_div and div_step.
// Ports: none (package).

package seq_div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // Bits needed to hold an iteration count from 0 up to and including width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
//
// Purpose: shift the next dividend bit into the partial remainder, subtract
// the divisor when it fits and report the resulting quotient bit.
// Ports:
//   r_i      partial remainder (WIDTH+1 bits)
//   q_msb_i  dividend/quotient register MSB shifted in this step
//   d_i      divisor
//   r_o      next partial remainder
//   q_bit_o  quotient bit produced by this step

module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] d_ext;

  assign t     = {r_i[WIDTH-1:0], q_msb_i};
  assign d_ext = {1'b0, d_i};

  // R < D holds between iterations, so r_i[WIDTH] is always 0 here; folding it
  // into the decision keeps the step correct for any incoming remainder.
  assign q_bit_o = r_i[WIDTH] | (t >= d_ext);
  assign r_o     = q_bit_o ? (t - d_ext) : t;

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - multi-cycle restoring unsigned/signed integer divider
//
// Purpose: accepts one dividend/divisor pair per start pulse in IDLE, retires
// one quotient bit per clock and presents quotient/remainder with a single
// cycle done pulse.
// Build option: define SEQ_DIV_SIGNED_EN for two's complement operands.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        division request, accepted only in IDLE
//   dividend     numerator, sampled on the accepting edge
//   divisor      denominator, sampled on the accepting edge
//   quotient     result, held until the next completion
//   remainder    result, held until the next completion
//   busy         high from the accepting edge until return to IDLE
//   done         one-cycle pulse, results valid while high
//   div_by_zero  divisor was zero for the current result

module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   step_r;
  logic             step_bit;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] load_dividend;
  logic [WIDTH-1:0] load_divisor;
  logic [WIDTH-1:0] fin_quot;
  logic [WIDTH-1:0] fin_rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[WIDTH-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .q_bit_o (step_bit)
  );

  assign accept = (state_q == S_IDLE) && start;
  assign q_step = {q_q[WIDTH-2:0], step_bit};

`ifdef SEQ_DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  assign load_dividend = dividend[WIDTH-1] ? -dividend : dividend;
  assign load_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign qneg_d        = accept ? (dividend[WIDTH-1] ^ divisor[WIDTH-1]) : qneg_q;
  assign rneg_d        = accept ? dividend[WIDTH-1] : rneg_q;
  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as unsigned, so /-1 wraps back
  // to -2^(WIDTH-1) without special casing.
  assign fin_quot      = qneg_q ? -q_step : q_step;
  assign fin_rem       = rneg_q ? -step_r[WIDTH-1:0] : step_r[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign load_dividend = dividend;
  assign load_divisor  = divisor;
  assign fin_quot      = q_step;
  assign fin_rem       = step_r[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // A zero divisor takes a single pass through CALC so the result
          // appears one edge after accept; d_q == 0 marks that pass and q_q
          // keeps the raw dividend to return as the remainder.
          r_d     = '0;
          d_d     = load_divisor;
          dbz_d   = 1'b0;
          state_d = S_CALC;
          if (divisor == '0) begin
            q_d   = dividend;
            cnt_d = CW'(1);
          end else begin
            q_d   = load_dividend;
            cnt_d = CW'(WIDTH);
          end
        end
      end
      S_CALC: begin
        r_d   = step_r;
        q_d   = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIN;
          if (d_q == '0) begin
            quot_d = '1;
            rem_d  = q_q;
            dbz_d  = 1'b1;
          end else begin
            quot_d = fin_quot;
            rem_d  = fin_rem;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - table-driven scoreboard bench for seq_div

module tb_seq_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  exp_t sb[$];

  seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      if (a == 8'h80 && b == 8'hFF) begin
        e.q = 8'h80;
        e.r = 8'h00;
      end else begin
        e.q = W'($signed(a) / $signed(b));
        e.r = W'($signed(a) % $signed(b));
      end
`else
      e.q = a / b;
      e.r = a % b;
`endif
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.z));
        check("busy_in_fin", 32'(busy), 32'd1);
      end
    end
  end

  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input exp_t e, input bit push);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Called at the negedge where lat0 edges have passed since the accept edge.
  task automatic wait_done(input int exp_lat, input int lat0, input string nm);
    int lat;
    lat = lat0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check(nm, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    vec_t vecs[$];
    exp_t e;

`ifdef SEQ_DIV_SIGNED_EN
    vecs.push_back('{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0});
    vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
    vecs.push_back('{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0});
    vecs.push_back('{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0});
    vecs.push_back('{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0});
    vecs.push_back('{8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0});
    vecs.push_back('{8'hFF, 8'h02, 8'h00, 8'hFF, 1'b0});
    vecs.push_back('{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1});
`else
    vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,   1'b0});
    vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0});
    vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254, 1'b0});
    vecs.push_back('{8'd128, 8'd3,   8'd42,  8'd2,   1'b0});
    vecs.push_back('{8'd7,   8'd2,   8'd3,   8'd1,   1'b0});
    vecs.push_back('{8'd200, 8'd13,  8'd15,  8'd5,   1'b0});
    vecs.push_back('{8'd255, 8'd16,  8'd15,  8'd15,  1'b0});
    vecs.push_back('{8'd37,  8'd0,   8'hFF,  8'd37,  1'b1});
`endif

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    // Table vectors, with latency checked against WIDTH edges (1 for zero).
    foreach (vecs[i]) begin
      e.q = vecs[i].q;
      e.r = vecs[i].r;
      e.z = vecs[i].z;
      start_div(vecs[i].a, vecs[i].b, e, 1'b1);
      wait_done(vecs[i].z ? 1 : W, 0, "latency_vec");
      @(negedge clk);
      check("idle_after_done", 32'(busy), 32'd0);
    end

    // Back-to-back: second start in the cycle right after done.
    start_div(8'd255, 8'd1, model(8'd255, 8'd1), 1'b1);
    wait_done(W, 0, "latency_b2b_first");
    start_div(8'd5, 8'd200, model(8'd5, 8'd200), 1'b1);
    wait_done(W, 0, "latency_b2b_second");

    // Start held during the done cycle is ignored.
    dividend = 8'd9;
    divisor  = 8'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 32'(busy), 32'd0);

    // Divide by zero, then the flag clears on the next accepted start.
    start_div(8'd37, 8'd0, model(8'd37, 8'd0), 1'b1);
    wait_done(1, 0, "latency_dbz");
    start_div(8'd9, 8'd4, model(8'd9, 8'd4), 1'b1);
    check("dbz_cleared_on_accept", 32'(div_by_zero), 32'd0);
    wait_done(W, 0, "latency_after_dbz");

    // Start pulse in the middle of a division is dropped.
    start_div(8'd200, 8'd13, model(8'd200, 8'd13), 1'b1);
    repeat (2) @(negedge clk);
    dividend = 8'd9;
    divisor  = 8'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(W, 3, "latency_busy_start");
    repeat (12) @(negedge clk);
    check("no_second_result", 32'(busy), 32'd0);

    // Reset mid-operation: no done, everything cleared, then a clean run.
    start_div(8'd100, 8'd7, e, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    repeat (12) @(negedge clk);
    start_div(8'd50, 8'd6, model(8'd50, 8'd6), 1'b1);
    wait_done(W, 0, "latency_after_rst");

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
